bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
- Upstream feeder for the serial Mealy sequence detector: accepts a parallel word over a valid/ready handshake and emits it one bit per clock, LSB first.
- ser_out drives the detector's serial input directly; clk and rst are shared with the detector.
- Replaces hand-driven bit loops in benches and gives the system a single-source serial stream with start/stop framing.

Parameters:
- WIDTH, 16, data word width in bits (≥2).
- IDX_W, $clog2(WIDTH), width of the bit index counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  a parallel word is presented on load_data.
- load_data  input  WIDTH  word to serialize.
- load_ready  output  1  block can accept a word (high only in IDLE).
- ser_en  input  1  downstream advance enable; low stalls shifting.
- ser_out  output  1  current serial bit (feeds the detector input).
- ser_valid  output  1  ser_out carries a meaningful bit this cycle.
- bit_idx  output  IDX_W  index of the bit currently on ser_out.
- done  output  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- Reset: state=IDLE, shreg=0, bit_idx=0, ser_out=0, ser_valid=0, done=0, load_ready=1 (from the first cycle after reset).
- rst has priority over every other input.
- Reset mid-word aborts the word, with no done pulse.
- FSM states: IDLE, SHIFT, plus PARITY when the optional feature is compiled in.
- IDLE:
  - load_ready=1, ser_valid=0, ser_out=0.
  - On an edge with load_valid=1: shreg<=load_data, bit_idx<=0, state<=SHIFT.
  - load_valid with load_ready=0 is ignored; the word is not captured.
- SHIFT:
  - load_ready=0, ser_valid=1, ser_out=shreg[0] (combinational from the register).
  - On an edge with ser_en=1: shreg shifts right (MSB filled with 0) and bit_idx increments.
  - ser_en=0 holds shreg, bit_idx and ser_out unchanged; stalls may last any length.
  - When bit_idx==WIDTH-1 and ser_en=1: next state is IDLE (or PARITY), bit_idx<=0, done<=1 for exactly one cycle.
- Latency: first bit appears on ser_out in the cycle after load acceptance. With ser_en held high, a word occupies exactly WIDTH cycles.
- Minimum spacing between words: one IDLE cycle. The next load can be accepted in the same cycle that done is high.
- The done pulse is registered: it is high in the first IDLE cycle and low otherwise.
- load_data is sampled only at acceptance; later changes have no effect.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After the last data bit, the FSM enters PARITY for one ser_en-qualified bit.
  - ser_out = even parity (XOR of the accepted word), held in a register computed at load.
  - ser_valid=1 and bit_idx=WIDTH during PARITY; IDX_W is widened to $clog2(WIDTH+1).
  - done pulses after the parity bit is consumed.
- Undefined: no PARITY state, no parity register; behaviour exactly as above.

Decomposition:
- Shared package ser_pkg:
  - state enum (IDLE, SHIFT, PARITY);
  - default WIDTH constant;
  - test word constant 16'h5772.
- No sub-module; the FSM and shift register stay in one module.
- The bench instantiates bit_serializer feeding the mealy detector.

Test Plan:
- Reset then load 16'h5772, ser_en=1:
  - ser_out over 16 cycles = 0,1,0,0,1,1,1,0,1,1,1,0,1,0,1,0;
  - bit_idx 0..15;
  - done high in cycle 17 only;
  - load_ready low in cycles 1–16.
- Stall: load 16'h8001, drop ser_en for 3 cycles at bit_idx=5:
  - ser_out and bit_idx hold at 0 and 5;
  - ser_out=1 at bit_idx=0 and 15 only;
  - word completes in 19 cycles.
- Busy load: pulse load_valid with 16'hFFFF at bit_idx=7 of a 16'h0000 word → ignored; ser_out stays 0 for all 16 bits.
- Reset mid-operation: assert rst at bit_idx=9:
  - next cycle ser_valid=0, load_ready=1, done=0;
  - a new 16'h0001 loads cleanly with first bit 1.
- Back-to-back: load_valid held high with 16'hAAAA then 16'h5555 → second word accepted in the done cycle; streams 0101… then 1010…, separated by exactly one ser_valid=0 cycle.
- SER_PARITY_EN: load 16'h5772 → 17th bit = 1 (nine ones), bit_idx=16, done after that bit; with 16'h0003 → parity bit 0.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer feeding the serial sequence detector.
package ser_pkg;

    localparam int unsigned SER_WIDTH = 16;
    localparam logic [15:0] SER_TEST_WORD = 16'h5772;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_e;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-in, LSB-first serial-out shifter with valid/ready load and stallable advance.
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH,
`ifdef SER_PARITY_EN
    parameter int unsigned IDX_W = $clog2(WIDTH + 1)
`else
    parameter int unsigned IDX_W = $clog2(WIDTH)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [IDX_W-1:0] bit_idx,
    output logic             done
);

    ser_state_e       state_q;
    ser_state_e       state_d;
    logic [WIDTH-1:0] shreg;
    logic             load_accept;
    logic             shift_en;
    logic             word_end;
    logic             last_data_bit;
`ifdef SER_PARITY_EN
    logic             par_q;
`endif

    assign last_data_bit = (bit_idx == IDX_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake and serial outputs decoded from the current state
    always_comb begin
        state_d     = state_q;
        load_accept = 1'b0;
        shift_en    = 1'b0;
        word_end    = 1'b0;
        load_ready  = 1'b0;
        ser_valid   = 1'b0;
        ser_out     = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    load_accept = 1'b1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = shreg[0];
                shift_en  = ser_en;
                if (ser_en && last_data_bit) begin
`ifdef SER_PARITY_EN
                    state_d  = PARITY;
`else
                    state_d  = IDLE;
                    word_end = 1'b1;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                ser_valid = 1'b1;
                ser_out   = par_q;
                if (ser_en) begin
                    state_d  = IDLE;
                    word_end = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shift register, bit index and registered done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_idx <= '0;
            done    <= 1'b0;
        end else begin
            done <= word_end;
            if (load_accept) begin
                shreg   <= load_data;
                bit_idx <= '0;
            end else if (shift_en) begin
                shreg   <= {1'b0, shreg[WIDTH-1:1]};
                bit_idx <= bit_idx + IDX_W'(1);
            end
            // The index wraps to zero once the whole frame has been consumed
            if (word_end) begin
                bit_idx <= '0;
            end
        end
    end

`ifdef SER_PARITY_EN
    // Parity of the accepted word, captured once so later load_data changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (load_accept) begin
            par_q <= ^load_data;
        end
    end
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized and directed bench for bit_serializer against a transaction-level frame model.
module tb_bit_serializer;
    import ser_pkg::*;

    localparam int unsigned W = SER_WIDTH;
`ifdef SER_PARITY_EN
    localparam int unsigned IW    = $clog2(W + 1);
    localparam int          NBITS = W + 1;
`else
    localparam int unsigned IW    = $clog2(W);
    localparam int          NBITS = W;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic [W-1:0]  load_data;
    logic          load_ready;
    logic          ser_en;
    logic          ser_out;
    logic          ser_valid;
    logic [IW-1:0] bit_idx;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the frame in flight and how many of its bits have been consumed
    bit           m_busy = 1'b0;
    int           m_pos  = 0;
    logic [W-1:0] m_word = '0;
    bit           m_done = 1'b0;

    bit_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .ser_en     (ser_en),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .bit_idx    (bit_idx),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_bit();
        if (!m_busy) return 1'b0;
        if (m_pos < W) return m_word[m_pos];
        return ^m_word;
    endfunction

    task automatic compare_outputs();
        check("load_ready", 32'(load_ready), 32'(!m_busy));
        check("ser_valid",  32'(ser_valid),  32'(m_busy));
        check("ser_out",    32'(ser_out),    32'(model_bit()));
        check("bit_idx",    32'(bit_idx),    m_busy ? 32'(m_pos) : 32'd0);
        check("done",       32'(done),       32'(m_done));
    endtask

    // One clock: drive inputs at negedge, advance the model at posedge, compare at next negedge
    task automatic tick(input logic r, input logic lv, input logic [W-1:0] ld, input logic en);
        rst        = r;
        load_valid = lv;
        load_data  = ld;
        ser_en     = en;
        @(posedge clk);
        m_done = 1'b0;
        if (r) begin
            m_busy = 1'b0;
            m_pos  = 0;
        end else if (!m_busy) begin
            if (lv) begin
                m_busy = 1'b1;
                m_pos  = 0;
                m_word = ld;
            end
        end else if (en) begin
            m_pos++;
            if (m_pos == NBITS) begin
                m_busy = 1'b0;
                m_pos  = 0;
                m_done = 1'b1;
            end
        end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle_tick();
        tick(1'b0, 1'b0, W'($urandom), 1'b1);
    endtask

    initial begin
        logic [W-1:0] cap;
        int           cnt;
        int           ones;

        rst = 1'b1; load_valid = 1'b0; load_data = '0; ser_en = 1'b0;
        @(negedge clk);
        tick(1'b1, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b1, '1, 1'b1);

        // Test word at full rate, stream captured and compared to the word itself
        tick(1'b0, 1'b1, W'(SER_TEST_WORD), 1'b1);
        for (int i = 0; i < W; i++) begin
            cap[i] = ser_out;
            tick(1'b0, 1'b0, W'($urandom), 1'b1);
        end
        check("stream_5772", 32'(cap), 32'(SER_TEST_WORD));
`ifdef SER_PARITY_EN
        check("parity_5772", 32'(ser_out), 32'd1);
        check("parity_idx", 32'(bit_idx), 32'(W));
        idle_tick();
`endif
        check("done_5772", 32'(done), 32'd1);
        idle_tick();
        check("done_width", 32'(done), 32'd0);

        // Stall at bit 5 for three cycles
        tick(1'b0, 1'b1, W'(16'h8001), 1'b1);
        cnt = 0; ones = 0;
        for (int k = 0; k < 25; k++) begin
            if (k == 6) begin
                check("stall_idx", 32'(bit_idx), 32'd5);
                check("stall_out", 32'(ser_out), 32'd0);
            end
            if (ser_valid) begin
                cnt++;
                if (ser_out) ones++;
            end
            tick(1'b0, 1'b0, W'($urandom), !(k >= 5 && k < 8));
        end
        check("stall_len", 32'(cnt), 32'(NBITS + 3));
        check("stall_ones", 32'(ones), 32'd2);

        // Load attempt while busy is ignored
        tick(1'b0, 1'b1, '0, 1'b1);
        ones = 0;
        for (int k = 0; k < NBITS + 1; k++) begin
            if (ser_out) ones++;
            tick(1'b0, (k == 7), '1, 1'b1);
        end
        check("busy_ones", 32'(ones), 32'd0);

        // Reset in the middle of a word
        tick(1'b0, 1'b1, W'($urandom), 1'b1);
        for (int k = 0; k < 9; k++) idle_tick();
        check("pre_rst_idx", 32'(bit_idx), 32'd9);
        tick(1'b1, 1'b0, '0, 1'b1);
        tick(1'b0, 1'b1, W'(16'h0001), 1'b1);
        check("post_rst_bit0", 32'(ser_out), 32'd1);
        for (int k = 0; k < NBITS + 1; k++) idle_tick();

        // Back-to-back words with load_valid held high
        tick(1'b0, 1'b1, W'(16'hAAAA), 1'b1);
        cnt = 0;
        for (int k = 0; k <= 2 * NBITS; k++) begin
            if (!ser_valid) cnt++;
            tick(1'b0, (k <= NBITS), W'(16'h5555), 1'b1);
        end
        check("b2b_gap", 32'(cnt), 32'd1);
        idle_tick();

`ifdef SER_PARITY_EN
        tick(1'b0, 1'b1, W'(16'h0003), 1'b1);
        for (int k = 0; k < W; k++) idle_tick();
        check("parity_0003", 32'(ser_out), 32'd0);
        idle_tick();
`endif

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            tick(($urandom_range(63) == 0), ($urandom_range(2) == 0),
                 W'($urandom), ($urandom_range(3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
